sumador_secuencial: RTL and testbench

//  Multi-cycle N-bit adder: adds two operands CHUNK bits per cycle, rippling the carry through a register between chunks.
//  ALU-side counterpart of the combinational ripple subtractor. Used where a full-width single-cycle carry chain misses timing.

---
 rtl/sumador_pkg.sv | 11 +
 rtl/sumador_bloque_cla.sv | 42 ++++
 rtl/sumador_secuencial.sv | 129 ++++++++++++
 tb/tb_sumador_secuencial.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sumador_pkg.sv
// Shared types and helpers for the multi-cycle chunked adder (sumador_secuencial).
package sumador_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sumador_estado_t;

    // Chunk counter width: max(1, $clog2(k)) so a single-chunk build still has a 1-bit counter.
    function automatic int ancho_contador(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/sumador_bloque_cla.sv
// Combinational W-bit carry-lookahead adder; also exposes the carry into its MSB for overflow detection.
module sumador_bloque_cla #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] suma,
    output logic         cout,
    output logic         c_msb
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat OR of generate terms gated by the propagate product above them.
    always_comb begin : lookahead
        logic prop;
        // NOTE: every variable written here gets a value first, so no path leaves a latch behind.
        c    = '0;
        prop = 1'b0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i];
            prop   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (prop & g[j]);
                prop   = prop & p[j];
            end
            c[i+1] = c[i+1] | (prop & cin);
        end
    end

    assign suma  = p ^ c[W-1:0];
    assign cout  = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/sumador_secuencial.sv
// Multi-cycle N-bit adder, CHUNK bits per cycle with a registered carry; valid/ready on both sides.
// Define SUMADOR_RESTA_EN to add the `resta` port (A - B - carry_in).
module sumador_secuencial
    import sumador_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] operando1,
    input  logic [N-1:0] operando2,
    input  logic         carry_in,
`ifdef SUMADOR_RESTA_EN
    input  logic         resta,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] resultado,
    output logic         carry_out,
    output logic         overflow,
    output logic         cero
);

    localparam int K  = N / CHUNK;
    localparam int CW = ancho_contador(K);

    if (N % CHUNK != 0) begin : g_chk_chunk
        $error("sumador_secuencial: N must be a multiple of CHUNK");
    end

    sumador_estado_t estado, estado_sig;
    logic [CW-1:0]   cnt;
    logic            carry_r;
    logic [N-1:0]    a_r, b_r;
    logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
    logic            chunk_cout, chunk_cmsb;
    logic            acepta, entrega, ultimo, resta_op;

`ifdef SUMADOR_RESTA_EN
    assign resta_op = resta;
`else
    assign resta_op = 1'b0;
`endif

    assign acepta  = (estado == IDLE) && in_valid;
    assign entrega = (estado == DONE) && out_ready;
    assign ultimo  = (cnt == CW'(K - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= IDLE;
        else        estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        unique case (estado)
            IDLE:    if (in_valid)  estado_sig = RUN;
            RUN:     if (ultimo)    estado_sig = DONE;
            DONE:    if (out_ready) estado_sig = IDLE;
            default:                estado_sig = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (estado == IDLE);
        out_valid = (estado == DONE);
        cero      = (estado == DONE) && (resultado == '0);
    end

    // NOTE: operand registers hold pure data and are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (acepta) begin
            a_r <= operando1;
            b_r <= operando2 ^ {N{resta_op}};
        end
    end

    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < K; i++) begin
            if (cnt == CW'(i)) begin
                chunk_a = a_r[i*CHUNK +: CHUNK];
                chunk_b = b_r[i*CHUNK +: CHUNK];
            end
        end
    end

    sumador_bloque_cla #(.W(CHUNK)) u_cla (
        .a     (chunk_a),
        .b     (chunk_b),
        .cin   (carry_r),
        .suma  (chunk_s),
        .cout  (chunk_cout),
        .c_msb (chunk_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            carry_r   <= 1'b0;
            resultado <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (acepta) begin
            cnt     <= '0;
            carry_r <= carry_in ^ resta_op;
        end else if (estado == RUN) begin
            for (int i = 0; i < K; i++) begin
                if (cnt == CW'(i)) resultado[i*CHUNK +: CHUNK] <= chunk_s;
            end
            carry_r <= chunk_cout;
            cnt     <= cnt + 1'b1;
            // Flags are captured only on the last chunk, i.e. on DONE entry.
            if (ultimo) begin
                carry_out <= chunk_cout;
                overflow  <= chunk_cmsb ^ chunk_cout;
            end
        end else if (entrega) begin
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sumador_secuencial.sv
// Self-checking bench for sumador_secuencial (N=8, CHUNK=4 plus a CHUNK=8 instance); honours SUMADOR_RESTA_EN.
module tb_sumador_secuencial;

    localparam int N = 8;
    localparam int K = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, carry_in, out_valid, out_ready;
    logic [N-1:0] operando1, operando2, resultado;
    logic         carry_out, overflow, cero;
`ifdef SUMADOR_RESTA_EN
    logic         resta_s, resta2;
`endif

    logic         in_valid2, in_ready2, carry_in2, out_valid2, out_ready2;
    logic [N-1:0] operando1_2, operando2_2, resultado2;
    logic         carry_out2, overflow2, cero2;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    sumador_secuencial #(.N(N), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .operando1(operando1), .operando2(operando2), .carry_in(carry_in),
`ifdef SUMADOR_RESTA_EN
        .resta(resta_s),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .resultado(resultado),
        .carry_out(carry_out), .overflow(overflow), .cero(cero)
    );

    sumador_secuencial #(.N(N), .CHUNK(8)) dut_k1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .operando1(operando1_2), .operando2(operando2_2), .carry_in(carry_in2),
`ifdef SUMADOR_RESTA_EN
        .resta(resta2),
`endif
        .out_valid(out_valid2), .out_ready(out_ready2), .resultado(resultado2),
        .carry_out(carry_out2), .overflow(overflow2), .cero(cero2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's definition.
    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic r,
                      input int hold, input string tag);
        logic [8:0] raw;
        int         s, to, lat;
        logic       exp_ov;
        if (r) begin
            raw = {1'b0, a} + {1'b0, ~b} + {8'b0, ~c};
            s   = int'($signed(a)) - int'($signed(b)) - int'(c);
        end else begin
            raw = {1'b0, a} + {1'b0, b} + {8'b0, c};
            s   = int'($signed(a)) + int'($signed(b)) + int'(c);
        end
        exp_ov = (s > 127) || (s < -128);

        to = 0;
        while (!in_ready && to < 50) begin @(posedge clk); #1; to++; end
        check({tag, "_ready"}, in_ready, 1);
        operando1 = a; operando2 = b; carry_in = c; in_valid = 1'b1;
`ifdef SUMADOR_RESTA_EN
        resta_s = r;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        check({tag, "_lat"}, lat, K);
        check({tag, "_res"}, resultado, raw[7:0]);
        check({tag, "_co"},  carry_out, raw[8]);
        check({tag, "_ov"},  overflow,  exp_ov);
        check({tag, "_z"},   cero,      raw[7:0] == 8'h00);

        // Stall in DONE while offering a fresh operation that must be ignored.
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1; operando1 = ~a; operando2 = a ^ b; carry_in = ~c;
            @(posedge clk); #1;
            check({tag, "_hold_res"}, resultado, raw[7:0]);
            check({tag, "_hold_co"},  carry_out, raw[8]);
            check({tag, "_hold_ov"},  overflow,  exp_ov);
            check({tag, "_hold_rdy"}, in_ready,  0);
            check({tag, "_hold_vld"}, out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_exit_vld"}, out_valid, 0);
        check({tag, "_exit_rdy"}, in_ready,  1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; carry_in = 1'b0;
        operando1 = '0; operando2 = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; carry_in2 = 1'b0;
        operando1_2 = '0; operando2_2 = '0;
`ifdef SUMADOR_RESTA_EN
        resta_s = 1'b0; resta2 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_rdy", in_ready, 1);
        check("rst_vld", out_valid, 0);
        check("rst_res", resultado, 0);
        check("rst_co",  carry_out, 0);
        check("rst_ov",  overflow, 0);
        check("rst_z",   cero, 0);

        op(8'h3C, 8'h05, 1'b0, 1'b0, 0, "t1");
        op(8'hFF, 8'h01, 1'b0, 1'b0, 0, "t2");
        op(8'h7F, 8'h00, 1'b1, 1'b0, 0, "t3");
        op(8'h9A, 8'h33, 1'b1, 1'b0, 5, "t4");
        op(8'h21, 8'h42, 1'b0, 1'b0, 0, "t4_next");

        // Reset one cycle into RUN discards the operation.
        operando1 = 8'hAA; operando2 = 8'h55; carry_in = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", out_valid, 0);
        check("mid_rst_res", resultado, 0);
        check("mid_rst_co",  carry_out, 0);
        check("mid_rst_ov",  overflow, 0);
        check("mid_rst_z",   cero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_rdy", in_ready, 1);
        op(8'h10, 8'h20, 1'b0, 1'b0, 0, "t5");

`ifdef SUMADOR_RESTA_EN
        op(8'h05, 8'h07, 1'b0, 1'b1, 0, "t6_sub");
`endif

        // Single-chunk instance: one cycle of RUN.
        @(negedge clk);
        operando1_2 = 8'h3C; operando2_2 = 8'h05; carry_in2 = 1'b0; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        check("k1_run_vld", out_valid2, 0);
        @(posedge clk); #1;
        check("k1_vld", out_valid2, 1);
        check("k1_res", resultado2, 8'h41);
        check("k1_co",  carry_out2, 0);
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        check("k1_exit_rdy", in_ready2, 1);

        for (int n = 0; n < 40; n++) begin
            logic r;
`ifdef SUMADOR_RESTA_EN
            r = 1'($urandom_range(0, 1));
`else
            r = 1'b0;
`endif
            op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), r,
               int'($urandom_range(0, 2)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
